// File: rtl/text_overlay_ctrl.sv
// Text overlay: 16-char buffer rendered via font ROM over a 128x8 pixel window.
// Latency: char_addr/row_addr 1 clock, text_on 2 clocks after drawX/drawY.
// Backpressure: wr_ready low during CLEAR or when clr_req is high. Blink via `TEXT_BLINK_EN.
module text_overlay_ctrl #(
    parameter int TEXT_X0      = 256,
    parameter int TEXT_Y0      = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] drawX,
    input  logic [9:0] drawY,
    input  logic       frame_start,
    input  logic       wr_valid,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_char,
    output logic       wr_ready,
    input  logic       clr_req,
    output logic       busy,
    output logic [7:0] char_addr,
    output logic [2:0] row_addr,
    input  logic [7:0] bitmap,
    output logic       text_on
);
    localparam logic [10:0] X_LO = 11'(TEXT_X0);
    localparam logic [10:0] X_HI = 11'(TEXT_X0 + 127);
    localparam logic [10:0] Y_LO = 11'(TEXT_Y0);
    localparam logic [10:0] Y_HI = 11'(TEXT_Y0 + 7);
    localparam logic [7:0]  SPACE = 8'h20;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_nx;
    logic [3:0] clr_idx, clr_idx_nx;
    logic [7:0] char_buf [16];

    logic [9:0] dx, dy;
    logic [3:0] col;
    logic [2:0] pix_bit, row;
    logic       in_win;
    logic [2:0] bit_d;
    logic       in_win_d;
    logic       visible;

    // Compare in 11 bits so coordinates left of / above the window never alias into it.
    assign in_win  = ({1'b0, drawX} >= X_LO) && ({1'b0, drawX} <= X_HI) &&
                     ({1'b0, drawY} >= Y_LO) && ({1'b0, drawY} <= Y_HI);
    assign dx      = drawX - 10'(TEXT_X0);
    assign dy      = drawY - 10'(TEXT_Y0);
    assign col     = dx[6:3];
    assign pix_bit = dx[2:0];
    assign row     = dy[2:0];

    logic unused_coord_bits;
    assign unused_coord_bits = ^{dx[9:7], dy[9:3]};

    assign busy     = (state == CLEAR);
    assign wr_ready = (state == IDLE) && !clr_req;

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx   = CLEAR;
                    clr_idx_nx = 4'd0;
                end
            end
            CLEAR: begin
                clr_idx_nx = clr_idx + 4'd1;
                if (clr_idx == 4'd15) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= 4'd0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    // Buffer has no reset of its own; the reset-entered CLEAR fills it with spaces.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            char_buf[clr_idx] <= SPACE;
        else if (wr_valid && wr_ready)
            char_buf[wr_idx] <= wr_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            char_addr <= SPACE;
            row_addr  <= 3'd0;
            bit_d     <= 3'd0;
            in_win_d  <= 1'b0;
            text_on   <= 1'b0;
        end else begin
            char_addr <= in_win ? char_buf[col] : SPACE;
            row_addr  <= row;
            bit_d     <= pix_bit;
            in_win_d  <= in_win;
            text_on   <= in_win_d && bitmap[3'd7 - bit_d] && visible;
        end
    end

`ifdef TEXT_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CW-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            visible   <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                visible   <= ~visible;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign visible = 1'b1;
`endif

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Randomized bench for text_overlay_ctrl with a pixel-level reference model and stub font ROM.
module tb_text_overlay_ctrl;
`ifdef TEXT_BLINK_EN
    localparam int BF = 2;
`else
    localparam int BF = 30;
`endif
    localparam int X0 = 256;
    localparam int Y0 = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] drawX = '0, drawY = '0;
    logic       frame_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_idx = '0;
    logic [7:0] wr_char = '0;
    logic       wr_ready;
    logic       clr_req = 1'b0;
    logic       busy;
    logic [7:0] char_addr;
    logic [2:0] row_addr;
    logic [7:0] bitmap;
    logic       text_on;

    logic       use_fixed = 1'b0;
    logic [7:0] fixed_bm = 8'h00;
    logic [7:0] mbuf [16];
    int checks = 0;
    int errors = 0;

    text_overlay_ctrl #(.TEXT_X0(X0), .TEXT_Y0(Y0), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .drawX(drawX), .drawY(drawY),
        .frame_start(frame_start), .wr_valid(wr_valid), .wr_idx(wr_idx),
        .wr_char(wr_char), .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy),
        .char_addr(char_addr), .row_addr(row_addr), .bitmap(bitmap), .text_on(text_on)
    );

    always #5 clk = ~clk;

    // Stub font: space is blank, everything else a hash of code and row.
    function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
        if (c == 8'h20) return 8'h00;
        return 8'((int'(c) * 13) + (int'(r) * 29) + 7);
    endfunction

    always_comb bitmap = use_fixed ? fixed_bm : font(char_addr, row_addr);

    function automatic bit m_in_win(input int x, input int y);
        return (x >= X0) && (x <= X0 + 127) && (y >= Y0) && (y <= Y0 + 7);
    endfunction

    function automatic logic [7:0] m_char(input int x, input int y);
        if (!m_in_win(x, y)) return 8'h20;
        return mbuf[(x - X0) / 8];
    endfunction

    function automatic logic m_pixel(input int x, input int y);
        logic [7:0] g;
        if (!m_in_win(x, y)) return 1'b0;
        g = font(mbuf[(x - X0) / 8], 3'(y - Y0));
        return g[7 - ((x - X0) % 8)];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [7:0] ch);
        wr_valid = 1'b1; wr_idx = idx; wr_char = ch;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready got %b want 1", wr_ready);
        end
        step();
        wr_valid = 1'b0;
        mbuf[idx] = ch;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({busy, wr_ready, char_addr, row_addr, text_on} !== {1'b1, 1'b0, 8'h20, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b rdy=%b ca=%h ra=%0d on=%b want 1 0 20 0 0",
                     busy, wr_ready, char_addr, row_addr, text_on);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL reset_busy cycle %0d got %b want 1", i, busy);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_done got busy=%b rdy=%b want 0 1", busy, wr_ready);
        end
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
        for (int c = 0; c < 16; c++) begin
            drawX = 10'(X0 + c * 8); drawY = 10'(Y0 + $urandom_range(0, 7));
            step();
            checks++;
            if (char_addr !== 8'h20) begin
                errors++;
                $display("FAIL reset_slot %0d got %h want 20", c, char_addr);
            end
        end
        for (int i = 0; i < 40; i++) begin
            drawX = 10'(X0 + $urandom_range(0, 127)); drawY = 10'(Y0 + $urandom_range(0, 7));
            step();
            checks++;
            if (text_on !== 1'b0) begin
                errors++;
                $display("FAIL reset_blank got %b want 0", text_on);
            end
        end
    endtask

    task automatic test_write_render();
        do_write(4'd0, 8'h50);
        use_fixed = 1'b1; fixed_bm = 8'h78;
        drawX = 10'd256; drawY = 10'd16;
        step();
        checks++;
        if (char_addr !== 8'h50 || row_addr !== 3'd0) begin
            errors++;
            $display("FAIL p_stage1 got ca=%h ra=%0d want 50 0", char_addr, row_addr);
        end
        drawX = 10'd257;
        step();
        checks++;
        if (text_on !== 1'b0) begin
            errors++;
            $display("FAIL p_bit0 got %b want 0", text_on);
        end
        step();
        checks++;
        if (text_on !== 1'b1) begin
            errors++;
            $display("FAIL p_bit1 got %b want 1", text_on);
        end
    endtask

    task automatic test_boundaries();
        int bx[4] = '{255, 384, 256, 256};
        int by[4] = '{16, 16, 24, 15};
        do_write(4'd15, 8'h41);
        use_fixed = 1'b1; fixed_bm = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            drawX = 10'(bx[i]); drawY = 10'(by[i]);
            step();
            checks++;
            if (char_addr !== 8'h20) begin
                errors++;
                $display("FAIL edge_ca (%0d,%0d) got %h want 20", bx[i], by[i], char_addr);
            end
            step();
            checks++;
            if (text_on !== 1'b0) begin
                errors++;
                $display("FAIL edge_on (%0d,%0d) got %b want 0", bx[i], by[i], text_on);
            end
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_random_render();
        int x, y;
        logic prev_on;
        use_fixed = 1'b0;
        for (int i = 0; i < 10; i++)
            do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        prev_on = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
            end else begin
                x = $urandom_range(248, 392); y = $urandom_range(12, 27);
            end
            drawX = 10'(x); drawY = 10'(y);
            step();
            checks++;
            if (char_addr !== m_char(x, y) ||
                (m_in_win(x, y) && row_addr !== 3'(y - Y0))) begin
                errors++;
                $display("FAIL rnd_stage1 (%0d,%0d) got ca=%h ra=%0d want ca=%h",
                         x, y, char_addr, row_addr, m_char(x, y));
            end
            if (n > 0) begin
                checks++;
                if (text_on !== prev_on) begin
                    errors++;
                    $display("FAIL rnd_text_on n=%0d got %b want %b", n, text_on, prev_on);
                end
            end
            prev_on = m_pixel(x, y);
        end
    endtask

    task automatic check_all_spaces(input string tag);
        for (int c = 0; c < 16; c++) begin
            drawX = 10'(X0 + c * 8); drawY = 10'(Y0);
            step();
            checks++;
            if (char_addr !== 8'h20) begin
                errors++;
                $display("FAIL %s slot %0d got %h want 20", tag, c, char_addr);
            end
        end
    endtask

    task automatic test_clear_collision();
        do_write(4'd3, 8'h33);
        clr_req = 1'b1; wr_valid = 1'b1; wr_idx = 4'd3; wr_char = 8'h41;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL collide_ready got %b want 0", wr_ready);
        end
        step();
        clr_req = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            clr_req = (i == 8);
            #1;
            checks++;
            if (busy !== 1'b1 || wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy cycle %0d got busy=%b rdy=%b want 1 0", i, busy, wr_ready);
            end
            step();
        end
        clr_req = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done got %b want 0", busy);
        end
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
        check_all_spaces("clear_slot");
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'h41 + 8'(i));
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        drawX = 10'(X0 + 8); drawY = 10'(Y0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (char_addr !== 8'h20 || text_on !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pipe got ca=%h on=%b want 20 0", char_addr, text_on);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL midreset_busy cycle %0d got %b want 1", i, busy);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done got %b want 0", busy);
        end
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
        check_all_spaces("midreset_slot");
    endtask

    task automatic test_blink();
        logic exp_on;
        do_write(4'd0, 8'h50);
        use_fixed = 1'b1; fixed_bm = 8'h78;
        drawX = 10'd257; drawY = 10'd16;
        step(); step();
        for (int p = 1; p <= 4; p++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step(); step(); step();
`ifdef TEXT_BLINK_EN
            exp_on = (((p / BF) % 2) == 0);
`else
            exp_on = 1'b1;
`endif
            checks++;
            if (text_on !== exp_on) begin
                errors++;
                $display("FAIL blink pulse %0d got %b want %b", p, text_on, exp_on);
            end
        end
        use_fixed = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
        #1;
        test_reset();
        test_write_render();
        test_boundaries();
        test_random_render();
        test_clear_collision();
        test_reset_mid_clear();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
